// File: rtl/terrain_crater_if.sv
// Bus bundle between the bomb stage, the crater carver and the terrain consumers.
// master drives explosion/restore requests; slave owns the terrain map and status.
interface terrain_crater_if #(
    parameter int TERRAIN_W = 512
);
    logic                 exploded;
    logic [9:0]           bombX;
    logic [9:0]           bombY;
    logic                 restore;
    logic [TERRAIN_W-1:0] terrain_out;
    logic                 busy;
    logic                 done;
    logic                 dropped;

    modport master (
        output exploded, bombX, bombY, restore,
        input  terrain_out, busy, done, dropped
    );

    modport slave (
        input  exploded, bombX, bombY, restore,
        output terrain_out, busy, done, dropped
    );
endinterface

// File: rtl/terrain_crater.sv
// Destructible terrain owner: carves a V crater one column per cycle (NUM_COLS+1 cycles to done).
// One explosion can wait in a pending slot while scanning; further ones are dropped.
module terrain_crater #(
    parameter int NUM_COLS    = 64,
    parameter int COL_W       = 10,
    parameter int H_BITS      = 8,
    parameter int INIT_HEIGHT = 80,
    parameter int RADIUS      = 16,
    parameter int Y_FLOOR     = 479
) (
    input  logic           clk,
    input  logic           reset_n,
    terrain_crater_if.slave bus
);
    localparam int                 COL_IDX_W = $clog2(NUM_COLS);
    localparam logic [H_BITS-1:0]  INIT_H    = H_BITS'(INIT_HEIGHT);
    localparam logic signed [11:0] RAD_S     = 12'(RADIUS);
    localparam logic signed [11:0] YFL_S     = 12'(Y_FLOOR);
    localparam logic signed [11:0] H_MAX     = 12'((1 << H_BITS) - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t               r_state;
    logic                 r_sync0, r_sync1, r_sync2;
    logic                 r_pend_vld;
    logic [9:0]           r_pend_x, r_pend_y;
    logic [9:0]           r_bx, r_by;
    logic [COL_IDX_W-1:0] r_col;
    logic [H_BITS-1:0]    r_height [NUM_COLS];
    logic                 r_busy, r_done, r_dropped;

    logic                 w_event;
    logic signed [11:0]   w_xc, w_diff, w_dx, w_target;
    logic                 w_in_range;
    logic [H_BITS-1:0]    w_clamped, w_cur_h, w_new_h;

    assign w_event = r_sync1 & ~r_sync2;

    // Crater profile for the column currently being scanned, evaluated in signed 12-bit.
    always_comb begin
        w_xc       = 12'(r_col) * 12'(COL_W) + 12'(COL_W / 2);
        w_diff     = w_xc - $signed({2'b00, r_bx});
        w_dx       = (w_diff < 12'sd0) ? -w_diff : w_diff;
        w_in_range = (w_dx <= RAD_S);
        w_target   = YFL_S - ($signed({2'b00, r_by}) + RAD_S - w_dx);
        if (w_target < 12'sd0)
            w_clamped = '0;
        else if (w_target > H_MAX)
            w_clamped = '1;
        else
            w_clamped = w_target[H_BITS-1:0];
        w_cur_h = r_height[r_col];
        w_new_h = (w_in_range && (w_clamped < w_cur_h)) ? w_clamped : w_cur_h;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sync0    <= 1'b0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_x   <= '0;
            r_pend_y   <= '0;
            r_bx       <= '0;
            r_by       <= '0;
            r_col      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dropped  <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) r_height[i] <= INIT_H;
        end else begin
            r_sync0   <= bus.exploded;
            r_sync1   <= r_sync0;
            r_sync2   <= r_sync1;
            r_done    <= 1'b0;
            r_dropped <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_bx    <= bus.bombX;
                        r_by    <= bus.bombY;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end else if (r_pend_vld) begin
                        r_bx       <= r_pend_x;
                        r_by       <= r_pend_y;
                        r_pend_vld <= 1'b0;
                        r_col      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end else if (bus.restore) begin
                        for (int i = 0; i < NUM_COLS; i++) r_height[i] <= INIT_H;
                    end
                end
                S_SCAN: begin
                    r_height[r_col] <= w_new_h;
                    if (r_col == COL_IDX_W'(NUM_COLS - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_col <= r_col + COL_IDX_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Explosions arriving outside IDLE queue once; a second one is lost.
            if (w_event && (r_state != S_IDLE)) begin
                if (!r_pend_vld) begin
                    r_pend_vld <= 1'b1;
                    r_pend_x   <= bus.bombX;
                    r_pend_y   <= bus.bombY;
                end else begin
                    r_dropped <= 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_out
        assign bus.terrain_out[c*H_BITS +: H_BITS] = r_height[c];
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.dropped = r_dropped;
endmodule

// File: tb/tb_terrain_crater.sv
// Randomised and directed bench for terrain_crater against a column-height reference model.
module tb_terrain_crater;
    localparam int NC = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    terrain_crater_if tb_if();

    terrain_crater dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (tb_if)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   model_h [NC];
    int   cyc = 0;
    int   done_cnt, drop_cnt, busy_cnt, first_done_cyc, last_busy_rise;
    logic prev_busy = 1'b0;

    function automatic void model_flat();
        for (int c = 0; c < NC; c++) model_h[c] = 80;
    endfunction

    function automatic void model_bomb(input int x, input int y);
        for (int c = 0; c < NC; c++) begin
            int xc, dx, t;
            xc = 10 * c + 5;
            dx = (xc > x) ? xc - x : x - xc;
            if (dx <= 16) begin
                t = 479 - (y + 16 - dx);
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                if (t < model_h[c]) model_h[c] = t;
            end
        end
    endfunction

    function automatic int col_h(input int c);
        return int'(tb_if.terrain_out[c*8 +: 8]);
    endfunction

    function automatic int terrain_diffs(output int first);
        int n;
        n = 0;
        first = -1;
        for (int c = 0; c < NC; c++) begin
            if (col_h(c) != model_h[c]) begin
                if (first < 0) first = c;
                n++;
            end
        end
        return n;
    endfunction

    task automatic clear_counts();
        done_cnt = 0; drop_cnt = 0; busy_cnt = 0;
        first_done_cyc = -1; last_busy_rise = -1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (tb_if.done) begin
            done_cnt++;
            if (first_done_cyc < 0) first_done_cyc = cyc;
        end
        if (tb_if.dropped) drop_cnt++;
        if (tb_if.busy) busy_cnt++;
        if (tb_if.busy && !prev_busy) last_busy_rise = cyc;
        prev_busy = tb_if.busy;
    endtask

    task automatic do_reset();
        tb_if.exploded = 1'b0;
        tb_if.restore  = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        model_flat();
        clear_counts();
    endtask

    task automatic start_bomb(input int x, input int y, output int lat);
        tb_if.bombX = 10'(x);
        tb_if.bombY = 10'(y);
        tb_if.exploded = 1'b1;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tb_if.busy) begin
                lat = i;
                break;
            end
        end
        tb_if.exploded = 1'b0;
    endtask

    task automatic pulse_event(input int x, input int y);
        tb_if.bombX = 10'(x);
        tb_if.bombY = 10'(y);
        tb_if.exploded = 1'b1;
        repeat (4) step();
        tb_if.exploded = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_dones(input int n, output logic ok);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt >= n) break;
            step();
        end
        ok = (done_cnt >= n);
        repeat (3) step();
    endtask

    task automatic test_reset();
        int d, f;
        tb_if.bombX = '0; tb_if.bombY = '0;
        tb_if.exploded = 1'b0; tb_if.restore = 1'b0;
        reset_n = 1'b0;
        step();
        model_flat();
        total++; if (tb_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", tb_if.busy); end
        total++; if (tb_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", tb_if.done); end
        total++; if (tb_if.dropped !== 1'b0) begin bad++; $display("FAIL reset_dropped: got %b expected 0", tb_if.dropped); end
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL reset_terrain: %0d cols differ, first col %0d", d, f); end
        do_reset();
    endtask

    task automatic test_crater_basic();
        int lat, d, f;
        logic ok;
        clear_counts();
        start_bomb(325, 399, lat);
        wait_dones(1, ok);
        model_bomb(325, 399);
        total++; if (!(lat >= 1 && lat <= 4)) begin bad++; $display("FAIL basic_busy_latency: got %0d expected 1..4", lat); end
        total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout: got no done expected done"); end
        total++; if (first_done_cyc - last_busy_rise + 1 !== 65) begin bad++; $display("FAIL basic_done_timing: got %0d expected 65", first_done_cyc - last_busy_rise + 1); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        total++; if (busy_cnt !== 64) begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 64", busy_cnt); end
        total++; if (col_h(32) !== 64) begin bad++; $display("FAIL basic_col32: got %0d expected 64", col_h(32)); end
        total++; if (col_h(31) !== 74) begin bad++; $display("FAIL basic_col31: got %0d expected 74", col_h(31)); end
        total++; if (col_h(33) !== 74) begin bad++; $display("FAIL basic_col33: got %0d expected 74", col_h(33)); end
        total++; if (col_h(30) !== 80 || col_h(34) !== 80) begin bad++; $display("FAIL basic_col30_34: got %0d/%0d expected 80/80", col_h(30), col_h(34)); end
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL basic_terrain: %0d cols differ, first col %0d", d, f); end
    endtask

    task automatic test_repeat();
        int lat, d, f;
        logic ok;
        clear_counts();
        start_bomb(325, 399, lat);
        wait_dones(1, ok);
        model_bomb(325, 399);
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL repeat_done_pulses: got %0d expected 1", done_cnt); end
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL repeat_terrain: %0d cols differ, first col %0d", d, f); end
    endtask

    task automatic test_clamps();
        int lat, d, f;
        logic ok;
        do_reset();
        start_bomb(325, 100, lat);
        wait_dones(1, ok);
        model_bomb(325, 100);
        total++; if (col_h(32) !== 80) begin bad++; $display("FAIL clamp_high_col32: got %0d expected 80", col_h(32)); end
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL clamp_high_terrain: %0d cols differ, first col %0d", d, f); end
        clear_counts();
        start_bomb(325, 470, lat);
        wait_dones(1, ok);
        model_bomb(325, 470);
        total++; if (col_h(32) !== 0) begin bad++; $display("FAIL clamp_low_col32: got %0d expected 0", col_h(32)); end
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL clamp_low_terrain: %0d cols differ, first col %0d", d, f); end
    endtask

    task automatic test_left_edge();
        int lat, d, f;
        logic ok;
        do_reset();
        start_bomb(0, 399, lat);
        wait_dones(1, ok);
        model_bomb(0, 399);
        total++; if (col_h(0) !== 69) begin bad++; $display("FAIL edge_col0: got %0d expected 69", col_h(0)); end
        total++; if (col_h(2) !== 80 || col_h(63) !== 80) begin bad++; $display("FAIL edge_col2_63: got %0d/%0d expected 80/80", col_h(2), col_h(63)); end
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL edge_terrain: %0d cols differ, first col %0d", d, f); end
    endtask

    task automatic test_restore();
        int lat, d, f;
        logic ok;
        tb_if.restore = 1'b1;
        step();
        tb_if.restore = 1'b0;
        model_flat();
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL restore_idle: %0d cols differ, first col %0d", d, f); end
        clear_counts();
        start_bomb(325, 399, lat);
        tb_if.restore = 1'b1;
        repeat (30) step();
        tb_if.restore = 1'b0;
        wait_dones(1, ok);
        model_bomb(325, 399);
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL restore_busy_ignored: %0d cols differ, first col %0d", d, f); end
    endtask

    task automatic test_queue();
        int lat, d, f;
        logic ok;
        do_reset();
        start_bomb(325, 399, lat);
        repeat (8) step();
        pulse_event(105, 399);
        pulse_event(600, 399);
        wait_dones(2, ok);
        model_bomb(325, 399);
        model_bomb(105, 399);
        total++; if (drop_cnt !== 1) begin bad++; $display("FAIL queue_dropped: got %0d expected 1", drop_cnt); end
        total++; if (done_cnt !== 2) begin bad++; $display("FAIL queue_done_count: got %0d expected 2", done_cnt); end
        total++; if (last_busy_rise - first_done_cyc !== 2) begin bad++; $display("FAIL queue_pending_start: got %0d expected 2", last_busy_rise - first_done_cyc); end
        total++; if (col_h(10) !== 64 || col_h(9) !== 74 || col_h(11) !== 74) begin bad++; $display("FAIL queue_b_crater: got %0d/%0d/%0d expected 74/64/74", col_h(9), col_h(10), col_h(11)); end
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL queue_terrain: %0d cols differ, first col %0d", d, f); end
    endtask

    task automatic test_reset_mid_scan();
        int lat, d, f;
        do_reset();
        start_bomb(325, 399, lat);
        pulse_event(105, 399);
        for (int i = 0; i < 100; i++) begin
            if (cyc - last_busy_rise >= 20) break;
            step();
        end
        reset_n = 1'b0;
        clear_counts();
        step();
        model_flat();
        d = terrain_diffs(f);
        total++; if (d !== 0) begin bad++; $display("FAIL midreset_terrain: %0d cols differ, first col %0d", d, f); end
        total++; if (tb_if.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b expected 0", tb_if.busy); end
        reset_n = 1'b1;
        repeat (100) step();
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d expected 0", done_cnt); end
        total++; if (busy_cnt !== 0) begin bad++; $display("FAIL midreset_pending_empty: got %0d busy cycles expected 0", busy_cnt); end
    endtask

    task automatic test_random();
        int lat, d, f, x, y;
        logic ok;
        for (int k = 0; k < 8; k++) begin
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(330, 475));
            if ($urandom_range(0, 3) == 0) begin
                tb_if.restore = 1'b1;
                step();
                tb_if.restore = 1'b0;
                step();
                model_flat();
            end
            clear_counts();
            start_bomb(x, y, lat);
            wait_dones(1, ok);
            model_bomb(x, y);
            total++; if (done_cnt !== 1) begin bad++; $display("FAIL random_done x=%0d y=%0d: got %0d expected 1", x, y, done_cnt); end
            d = terrain_diffs(f);
            total++; if (d !== 0) begin bad++; $display("FAIL random_terrain x=%0d y=%0d: %0d cols differ, first col %0d got %0d expected %0d", x, y, d, f, col_h(f < 0 ? 0 : f), model_h[f < 0 ? 0 : f]); end
        end
    endtask

    initial begin
        test_reset();
        test_crater_basic();
        test_repeat();
        test_clamps();
        test_left_edge();
        test_restore();
        test_queue();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
